// File: rtl/mat4_vec4_mul_pkg.sv
// Shared types and constants for the matrix-vector transform block.
// Contents: default element width/fraction, vec4_t, FSM state enum and
// a helper returning the product shift for fixed-point vs integer mode.
package mat4_vec4_mul_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_FRAC_BITS = DEF_WIDTH / 2;

  typedef logic signed [3:0][DEF_WIDTH-1:0] vec4_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } mv_state_t;

  // Right shift applied to a 2*WIDTH product to return to operand format.
  function automatic int unsigned frac_shift(input bit fixed_point, input int unsigned width);
    return fixed_point ? (width / 2) : 0;
  endfunction

endpackage

// File: rtl/mat4_vec4_mul_if.sv
// Job/result bus of the matrix-vector transform block.
// Source side: m_in, v_in, valid_in (job) and ready_in (result sink ready).
// Block side:  ready_out, result_out, valid_out, busy_out.
interface mat4_vec4_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic [16*WIDTH-1:0] m_in;
  logic [4*WIDTH-1:0]  v_in;
  logic                valid_in;
  logic                ready_out;
  logic [4*WIDTH-1:0]  result_out;
  logic                valid_out;
  logic                ready_in;
  logic                busy_out;

  modport slave (
    input  m_in, v_in, valid_in, ready_in,
    output ready_out, result_out, valid_out, busy_out
  );

  modport master (
    output m_in, v_in, valid_in, ready_in,
    input  ready_out, result_out, valid_out, busy_out
  );
endinterface

// File: rtl/mat4_vec4_mul_dot.sv
// 3-cycle 4-element dot product: inputs registered, truncated products
// registered, wrapped sum registered. No reset on the datapath registers.
// Ports: clk_in; a_i/b_i 4 packed WIDTH-bit elements; dot_o WIDTH-bit result.
module mat4_vec4_mul_dot
  import mat4_vec4_mul_pkg::*;
#(
  parameter bit          FIXED_POINT = 1'b1,
  parameter int unsigned WIDTH       = DEF_WIDTH
) (
  input  logic                 clk_in,
  input  logic [4*WIDTH-1:0]   a_i,
  input  logic [4*WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]     dot_o
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned LO = frac_shift(FIXED_POINT, WIDTH);

  logic [4*WIDTH-1:0] a_q, b_q;
  logic [4*WIDTH-1:0] prod_d, prod_q;
  logic [WIDTH-1:0]   sum_c, sum_q;

  // Full-precision signed product, then keep WIDTH bits starting at LO.
  for (genvar i = 0; i < 4; i++) begin : g_mul
    logic signed [WIDTH-1:0] a_e, b_e;
    logic signed [PW-1:0]    prod_c;
    assign a_e    = a_q[i*WIDTH +: WIDTH];
    assign b_e    = b_q[i*WIDTH +: WIDTH];
    assign prod_c = PW'(a_e) * PW'(b_e);
    assign prod_d[i*WIDTH +: WIDTH] = WIDTH'(prod_c >>> LO);
  end

  // Sum wraps modulo 2^WIDTH.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 4; i++) begin
      sum_c = sum_c + prod_q[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_in) begin
    a_q    <= a_i;
    b_q    <= b_i;
    prod_q <= prod_d;
    sum_q  <= sum_c;
  end

  assign dot_o = sum_q;

endmodule

// File: rtl/mat4_vec4_mul.sv
// Matrix(4x4) x vector(4) issuer/collector around one dot-product pipeline.
// Ports: clk_in, rst_in (sync, active-low), bus (slave modport):
//   m_in/v_in/valid_in job in, ready_out job accept, result_out/valid_out
//   result, ready_in result accept, busy_out job in flight.
module mat4_vec4_mul
  import mat4_vec4_mul_pkg::*;
#(
  parameter bit          FIXED_POINT = 1'b1,
  parameter int unsigned WIDTH       = DEF_WIDTH
) (
  input  logic          clk_in,
  input  logic          rst_in,
  mat4_vec4_mul_if.slave bus
);
  localparam int unsigned ROW_W = 4 * WIDTH;

  mv_state_t state_q, state_d;

  logic [16*WIDTH-1:0] m_q;
  logic [ROW_W-1:0]    v_q;
  logic [1:0]          row_cnt_q, row_cnt_d;
  logic [1:0]          res_cnt_q, res_cnt_d;
  logic [2:0]          tag_q, tag_d;
  logic [ROW_W-1:0]    res_q, res_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic                accept_c;
  logic                issue_c;
  logic                capture_c;
  logic [ROW_W-1:0]    row_c;
  logic [WIDTH-1:0]    dot_c;

  assign accept_c  = bus.valid_in && ready_q;
  assign issue_c   = (state_q == ISSUE);
  // Tag bit 2 lines up with the dot-product output of a valid row.
  assign capture_c = tag_q[2];
  assign row_c     = m_q[32'(row_cnt_q) * ROW_W +: ROW_W];

  mat4_vec4_mul_dot #(
    .FIXED_POINT (FIXED_POINT),
    .WIDTH       (WIDTH)
  ) u_dot (
    .clk_in (clk_in),
    .a_i    (row_c),
    .b_i    (v_q),
    .dot_o  (dot_c)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ISSUE;
      ISSUE:   if (row_cnt_q == 2'd3) state_d = DRAIN;
      DRAIN:   if (capture_c && (res_cnt_q == 2'd3)) state_d = HOLD;
      HOLD:    if (bus.ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, tags, result collection and registered handshake outputs.
  always_comb begin
    row_cnt_d = row_cnt_q;
    res_cnt_d = res_cnt_q;
    tag_d     = {tag_q[1:0], issue_c};
    res_d     = res_q;
    ready_d   = (state_d == IDLE);
    valid_d   = (state_d == HOLD);
    busy_d    = (state_d != IDLE);

    if (accept_c) begin
      row_cnt_d = 2'd0;
      res_cnt_d = 2'd0;
    end
    if (issue_c) begin
      row_cnt_d = row_cnt_q + 2'd1;
    end
    if (capture_c) begin
      res_d[32'(res_cnt_q) * WIDTH +: WIDTH] = dot_c;
      res_cnt_d = res_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      row_cnt_q <= 2'd0;
      res_cnt_q <= 2'd0;
      tag_q     <= 3'd0;
      res_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      row_cnt_q <= row_cnt_d;
      res_cnt_q <= res_cnt_d;
      tag_q     <= tag_d;
      res_q     <= res_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // Operand capture; only an accepted job is latched.
  always_ff @(posedge clk_in) begin
    if (accept_c) begin
      m_q <= bus.m_in;
      v_q <= bus.v_in;
    end
  end

  assign bus.ready_out  = ready_q;
  assign bus.valid_out  = valid_q;
  assign bus.busy_out   = busy_q;
  assign bus.result_out = res_q;

endmodule

// File: tb/tb_mat4_vec4_mul.sv
// Directed bench: integer and Q16.16 instances share clock and reset;
// sel routes the common drive/observe signals to one of them.
module tb_mat4_vec4_mul;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  mat4_vec4_mul_if #(.WIDTH(32)) bus_i ();
  mat4_vec4_mul_if #(.WIDTH(32)) bus_q ();

  mat4_vec4_mul #(.FIXED_POINT(1'b0), .WIDTH(32)) dut_i (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_i)
  );

  mat4_vec4_mul #(.FIXED_POINT(1'b1), .WIDTH(32)) dut_q (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_q)
  );

  bit           sel = 1'b0;
  logic [511:0] m_drv = '0;
  logic [127:0] v_drv = '0;
  logic         valid_drv = 1'b0;
  logic         ready_drv = 1'b1;

  assign bus_i.m_in     = m_drv;
  assign bus_i.v_in     = v_drv;
  assign bus_i.valid_in = valid_drv & ~sel;
  assign bus_i.ready_in = sel ? 1'b1 : ready_drv;
  assign bus_q.m_in     = m_drv;
  assign bus_q.v_in     = v_drv;
  assign bus_q.valid_in = valid_drv & sel;
  assign bus_q.ready_in = sel ? ready_drv : 1'b1;

  logic         o_ready, o_valid, o_busy;
  logic [127:0] o_res;
  assign o_ready = sel ? bus_q.ready_out  : bus_i.ready_out;
  assign o_valid = sel ? bus_q.valid_out  : bus_i.valid_out;
  assign o_busy  = sel ? bus_q.busy_out   : bus_i.busy_out;
  assign o_res   = sel ? bus_q.result_out : bus_i.result_out;

  int total = 0;
  int bad   = 0;

  function automatic logic [127:0] pack4(input logic [31:0] e0, input logic [31:0] e1,
                                         input logic [31:0] e2, input logic [31:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [511:0] mat(input logic [127:0] r0, input logic [127:0] r1,
                                       input logic [127:0] r2, input logic [127:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  logic [511:0] m1, m2, m3, m4;
  logic [127:0] v1, v2, v3, v4, e1, e2, e3, e4;

  // One job: accept, latency, result, optional backpressure, handshake.
  task automatic job(input bit fp, input logic [511:0] m, input logic [127:0] v,
                     input logic [127:0] exp, input int hold, input string name);
    int lat;
    logic [127:0] held;
    sel = fp;
    ready_drv = (hold == 0);
    @(negedge clk_in);
    m_drv = m; v_drv = v; valid_drv = 1'b1;
    lat = 0;
    while (!o_ready && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL %s accept: ready_out=%b required 1", name, o_ready); end
    // This negedge is the accept cycle; the job is latched on the next posedge.
    @(negedge clk_in);
    valid_drv = 1'b0;
    total++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
      bad++; $display("FAIL %s inflight: ready=%b busy=%b required 0/1", name, o_ready, o_busy);
    end
    lat = 1;
    while (o_valid !== 1'b1 && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL %s latency: got %0d required 8", name, lat); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (o_res[i*32 +: 32] !== exp[i*32 +: 32]) begin
        bad++; $display("FAIL %s r[%0d]: got %h required %h", name, i, o_res[i*32 +: 32], exp[i*32 +: 32]);
      end
    end
    held = o_res;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_in);
      total++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_res !== held) begin
        bad++; $display("FAIL %s hold%0d: valid=%b ready=%b res=%h required 1/0/%h", name, k, o_valid, o_ready, o_res, held);
      end
    end
    ready_drv = 1'b1;
    @(negedge clk_in);
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_res !== held) begin
      bad++; $display("FAIL %s handshake: valid=%b ready=%b busy=%b res=%h required 0/1/0/%h", name, o_valid, o_ready, o_busy, o_res, held);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL reset%0d ready: got %b required 1", s, o_ready); end
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL reset%0d valid: got %b required 0", s, o_valid); end
      total++;
      if (o_busy !== 1'b0) begin bad++; $display("FAIL reset%0d busy: got %b required 0", s, o_busy); end
      total++;
      if (o_res !== 128'd0) begin bad++; $display("FAIL reset%0d result: got %h required 0", s, o_res); end
    end
    sel = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_integer();
    job(1'b0, m1, v1, e1, 0, "int");
  endtask

  task automatic test_fixed_point();
    job(1'b1, m2, v2, e2, 0, "q16");
  endtask

  task automatic test_wrap();
    job(1'b0, m3, v3, e3, 0, "wrap");
  endtask

  task automatic test_backpressure();
    job(1'b0, m4, v4, e4, 5, "bp");
  endtask

  task automatic test_reset_mid_job();
    int seen;
    sel = 1'b0;
    ready_drv = 1'b1;
    @(negedge clk_in);
    m_drv = m1; v_drv = v1; valid_drv = 1'b1;
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL midrst ready_before: got %b required 1", o_ready); end
    @(negedge clk_in);
    valid_drv = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_res !== 128'd0) begin
      bad++; $display("FAIL midrst after: valid=%b ready=%b busy=%b res=%h required 0/1/0/0", o_valid, o_ready, o_busy, o_res);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk_in);
      if (o_valid === 1'b1 || o_res !== 128'd0) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midrst spurious: got %0d cycles required 0", seen); end
    job(1'b0, m4, v4, e4, 0, "midrst_new");
  endtask

  task automatic test_back_to_back();
    logic [511:0] bm [3];
    logic [127:0] bv [3];
    logic [127:0] be [3];
    logic [127:0] got [3];
    int acc [3];
    int gotc [3];
    int idx, nres;
    bit adv;
    bm[0] = m1; bv[0] = v1; be[0] = e1;
    bm[1] = m3; bv[1] = v3; be[1] = e3;
    bm[2] = m4; bv[2] = v4; be[2] = e4;
    for (int k = 0; k < 3; k++) begin acc[k] = -100; gotc[k] = -100; got[k] = '0; end
    sel = 1'b0;
    ready_drv = 1'b1;
    idx = 0; nres = 0; adv = 1'b0;
    @(negedge clk_in);
    m_drv = bm[0]; v_drv = bv[0]; valid_drv = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (o_valid === 1'b1) begin
        if (nres < 3) begin got[nres] = o_res; gotc[nres] = c; end
        nres++;
      end
      if (valid_drv && o_ready === 1'b1) begin
        acc[idx] = c;
        adv = 1'b1;
      end
      @(negedge clk_in);
      if (adv) begin
        adv = 1'b0;
        idx++;
        if (idx < 3) begin m_drv = bm[idx]; v_drv = bv[idx]; end
        else valid_drv = 1'b0;
      end
    end
    valid_drv = 1'b0;
    total++;
    if (nres !== 3) begin bad++; $display("FAIL b2b count: got %0d results required 3", nres); end
    total++;
    if (acc[1] - acc[0] !== 9) begin bad++; $display("FAIL b2b period01: got %0d required 9", acc[1] - acc[0]); end
    total++;
    if (acc[2] - acc[1] !== 9) begin bad++; $display("FAIL b2b period12: got %0d required 9", acc[2] - acc[1]); end
    total++;
    if (gotc[0] - acc[0] !== 8) begin bad++; $display("FAIL b2b latency: got %0d required 8", gotc[0] - acc[0]); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got[k] !== be[k]) begin bad++; $display("FAIL b2b job%0d: got %h required %h", k, got[k], be[k]); end
    end
  endtask

  initial begin
    m1 = mat(pack4(1, 2, 3, 4), pack4(0, 1, 0, 0), pack4(-1, -1, -1, -1), pack4(2, 0, 0, 1));
    v1 = pack4(5, 6, 7, 8);
    e1 = pack4(70, 6, -26, 18);

    m2 = mat(pack4(32'h0001_0000, 0, 0, 32'h0003_0000), pack4(0, 32'h0001_0000, 0, 0),
             pack4(0, 0, 32'h0001_0000, 0), pack4(0, 0, 0, 32'h0001_0000));
    v2 = pack4(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000);
    e2 = pack4(32'h0004_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000);

    m3 = mat(pack4(32'h7FFF_FFFF, 1, 0, 0), pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), pack4(0, 0, 0, 0));
    v3 = pack4(1, 1, 0, 0);
    e3 = pack4(32'h8000_0000, 0, 0, 0);

    m4 = mat(pack4(1, 0, 0, 0), pack4(0, 0, 0, -1), pack4(3, 3, 3, 3), pack4(0, 0, 2, 0));
    v4 = pack4(10, -20, 30, -40);
    e4 = pack4(10, 40, -60, 60);

    test_reset();
    test_integer();
    test_fixed_point();
    test_wrap();
    test_backpressure();
    test_reset_mid_job();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
